// File: rtl/phase_seq_pkg.sv
// ---------------------------------------------------------------------------
// phase_seq_pkg
// Shared definitions for the phase sequencer:
//   seq_state_t      - sequencer FSM state (IDLE / RUN)
//   DEF_CNT_W        - default timer / duration width in bits
//   DEF_DUR_0..4     - duration table contents loaded at reset (cycles)
// ---------------------------------------------------------------------------
package phase_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam int DEF_CNT_W = 22;

  localparam int DEF_DUR_0 = 2000000;
  localparam int DEF_DUR_1 = 1950;
  localparam int DEF_DUR_2 = 1850;
  localparam int DEF_DUR_3 = 1850;
  localparam int DEF_DUR_4 = 76500;

endpackage

// File: rtl/phase_sequencer_interval_timer.sv
// ---------------------------------------------------------------------------
// interval_timer
// Loadable down-counter that stops at zero.
// Ports:
//   CLK, RESET_N - clock (rising edge), asynchronous active-low reset
//   LOAD         - load LOAD_VAL into the counter (wins over EN)
//   LOAD_VAL     - value to load
//   EN           - decrement enable
//   COUNT        - current count
//   EXPIRE       - count is zero while enabled
// ---------------------------------------------------------------------------
module interval_timer
  import phase_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] LOAD_VAL,
  input  logic             EN,
  output logic [CNT_W-1:0] COUNT,
  output logic             EXPIRE
);

  // The zero check guards the decrement so the counter never wraps.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= '0;
    end else if (LOAD) begin
      COUNT <= LOAD_VAL;
    end else if (EN && (COUNT != '0)) begin
      COUNT <= COUNT - CNT_W'(1);
    end
  end

  assign EXPIRE = (COUNT == '0) && EN;

endmodule

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// Steps an interval timer through a run-time writable table of phase
// durations and reports the active phase.
// Ports:
//   CLK, RESET_N - clock (rising edge), asynchronous active-low reset
//   START        - begin a sequence (accepted in IDLE only)
//   ABORT        - terminate the sequence, highest priority
//   PAUSE        - freeze the timer while running
//   LOOP         - wrap to phase 0 after the last phase instead of finishing
//   CFG_WE/ADDR/DATA - duration table write port (any state)
//   READY, BUSY  - registered IDLE / RUN indicators
//   PHASE        - current phase index
//   PHASE_STB    - one-cycle pulse on every phase completion
//   DONE         - one-cycle pulse on normal sequence completion
// ---------------------------------------------------------------------------
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter  int NUM_PHASES = 5,
  parameter  int CNT_W      = DEF_CNT_W,
  localparam int ADDR_W     = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic              PAUSE,
  input  logic              LOOP,
  input  logic              CFG_WE,
  input  logic [ADDR_W-1:0] CFG_ADDR,
  input  logic [CNT_W-1:0]  CFG_DATA,
  output logic              READY,
  output logic              BUSY,
  output logic [ADDR_W-1:0] PHASE,
  output logic              PHASE_STB,
  output logic              DONE
);

  // The table covers the full address space so any PHASE value indexes a
  // real entry; entries beyond NUM_PHASES hold 1 and are never written.
  localparam int TABLE_DEPTH = 1 << ADDR_W;

  function automatic logic [CNT_W-1:0] defaultDur(input int idx);
    logic [CNT_W-1:0] val;
    case (idx)
      0:       val = CNT_W'(DEF_DUR_0);
      1:       val = CNT_W'(DEF_DUR_1);
      2:       val = CNT_W'(DEF_DUR_2);
      3:       val = CNT_W'(DEF_DUR_3);
      4:       val = CNT_W'(DEF_DUR_4);
      default: val = CNT_W'(1);
    endcase
    return val;
  endfunction

  // A phase of duration d lasts max(d,1) cycles, so the timer loads max(d,1)-1.
  function automatic logic [CNT_W-1:0] loadValue(input logic [CNT_W-1:0] dur);
    return (dur == '0) ? '0 : dur - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  durTable [TABLE_DEPTH];
  seq_state_t        state, stateNext;
  logic [ADDR_W-1:0] phaseNext, phaseInc;
  logic              stbNext, doneNext;
  logic              timerLoad, timerEn, timerExpire;
  logic [CNT_W-1:0]  loadVal;
  logic [CNT_W-1:0]  unusedCount;

  // Writes only reach the table; the running countdown is untouched until
  // the entry is loaded again.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        durTable[i] <= defaultDur(i);
      end
    end else if (CFG_WE && (int'(CFG_ADDR) < NUM_PHASES)) begin
      durTable[CFG_ADDR] <= CFG_DATA;
    end
  end

  assign timerEn  = (state == RUN) && !PAUSE;
  assign phaseInc = PHASE + ADDR_W'(1);

  interval_timer #(
    .CNT_W(CNT_W)
  ) timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .LOAD    (timerLoad),
    .LOAD_VAL(loadVal),
    .EN      (timerEn),
    .COUNT   (unusedCount),
    .EXPIRE  (timerExpire)
  );

  // Next-state logic; ABORT is checked before the phase-end path so it
  // suppresses PHASE_STB and DONE.
  always_comb begin
    stateNext = state;
    phaseNext = PHASE;
    stbNext   = 1'b0;
    doneNext  = 1'b0;
    timerLoad = 1'b0;
    loadVal   = loadValue(durTable[0]);
    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          stateNext = RUN;
          phaseNext = '0;
          timerLoad = 1'b1;
        end
      end
      RUN: begin
        if (ABORT) begin
          stateNext = IDLE;
          phaseNext = '0;
        end else if (timerExpire) begin
          stbNext = 1'b1;
          if (int'(PHASE) < NUM_PHASES - 1) begin
            phaseNext = phaseInc;
            timerLoad = 1'b1;
            loadVal   = loadValue(durTable[phaseInc]);
          end else if (LOOP) begin
            phaseNext = '0;
            timerLoad = 1'b1;
          end else begin
            stateNext = IDLE;
            phaseNext = '0;
            doneNext  = 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        phaseNext = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      PHASE     <= '0;
      PHASE_STB <= 1'b0;
      DONE      <= 1'b0;
      READY     <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state     <= stateNext;
      PHASE     <= phaseNext;
      PHASE_STB <= stbNext;
      DONE      <= doneNext;
      READY     <= (stateNext == IDLE);
      BUSY      <= (stateNext == RUN);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
// Directed and randomized stimulus for phase_sequencer, checked every cycle
// against a cycles-remaining model of the phase schedule.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

  localparam int NUM_PHASES = 5;
  localparam int CNT_W      = 22;
  localparam int ADDR_W     = 3;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              START, ABORT, PAUSE, LOOP, CFG_WE;
  logic [ADDR_W-1:0] CFG_ADDR;
  logic [CNT_W-1:0]  CFG_DATA;
  logic              READY, BUSY, PHASE_STB, DONE;
  logic [ADDR_W-1:0] PHASE;

  int errors = 0;
  int checks = 0;

  // Reference model: running flag, phase, cycles left in the phase
  bit mRun, mStb, mDone;
  int mPhase, mRemain;
  int mDur [NUM_PHASES];

  int phaseLog [$];
  int phaseCount [NUM_PHASES];

  phase_sequencer dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .ABORT    (ABORT),
    .PAUSE    (PAUSE),
    .LOOP     (LOOP),
    .CFG_WE   (CFG_WE),
    .CFG_ADDR (CFG_ADDR),
    .CFG_DATA (CFG_DATA),
    .READY    (READY),
    .BUSY     (BUSY),
    .PHASE    (PHASE),
    .PHASE_STB(PHASE_STB),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic modelReset();
    mRun   = 1'b0;
    mStb   = 1'b0;
    mDone  = 1'b0;
    mPhase = 0;
    mRemain = 0;
    mDur   = '{2000000, 1950, 1850, 1850, 76500};
  endtask

  // One clock edge of the schedule, using the inputs present at that edge.
  task automatic modelStep();
    mStb  = 1'b0;
    mDone = 1'b0;
    if (!mRun) begin
      if (START && !ABORT) begin
        mRun    = 1'b1;
        mPhase  = 0;
        mRemain = eff(mDur[0]);
      end
    end else if (ABORT) begin
      mRun   = 1'b0;
      mPhase = 0;
    end else if (!PAUSE) begin
      mRemain--;
      if (mRemain == 0) begin
        mStb = 1'b1;
        if (mPhase < NUM_PHASES - 1) begin
          mPhase++;
          mRemain = eff(mDur[mPhase]);
        end else if (LOOP) begin
          mPhase  = 0;
          mRemain = eff(mDur[0]);
        end else begin
          mRun   = 1'b0;
          mPhase = 0;
          mDone  = 1'b1;
        end
      end
    end
    if (CFG_WE && (int'(CFG_ADDR) < NUM_PHASES)) mDur[CFG_ADDR] = int'(CFG_DATA);
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("ready", 32'(READY), 32'(!mRun));
    checkValue("busy", 32'(BUSY), 32'(mRun));
    checkValue("phase", 32'(PHASE), 32'(mPhase));
    checkValue("phase_stb", 32'(PHASE_STB), 32'(mStb));
    checkValue("done", 32'(DONE), 32'(mDone));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RESET_N === 1'b1) modelStep();
    #1;
    checkOutput();
  endtask

  task automatic cfgWrite(input int addr, input int data);
    CFG_WE   = 1'b1;
    CFG_ADDR = ADDR_W'(addr);
    CFG_DATA = CNT_W'(data);
    tick();
    CFG_WE   = 1'b0;
  endtask

  task automatic startSeq();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic abortSeq();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
  endtask

  // Runs until BUSY drops, logging PHASE for every busy cycle.
  task automatic runUntilIdle(input int budget, output int n);
    phaseLog.delete();
    for (int k = 0; k < NUM_PHASES; k++) phaseCount[k] = 0;
    n = 0;
    while (BUSY === 1'b1 && n < budget) begin
      phaseLog.push_back(int'(PHASE));
      if (int'(PHASE) < NUM_PHASES) phaseCount[PHASE]++;
      n++;
      tick();
    end
    checkValue("runCompletes", 32'(BUSY), 32'd0);
  endtask

  // One cycle of randomized stimulus.
  task automatic applyStimulus();
    START    = ($urandom_range(0, 3) == 0);
    ABORT    = ($urandom_range(0, 39) == 0);
    PAUSE    = ($urandom_range(0, 4) == 0);
    if ($urandom_range(0, 19) == 0) LOOP = ~LOOP;
    CFG_WE   = ($urandom_range(0, 9) == 0);
    CFG_ADDR = ADDR_W'($urandom_range(0, 7));
    CFG_DATA = CNT_W'($urandom_range(0, 4));
    tick();
  endtask

  initial begin
    int n;
    int waitCnt;
    int pauseLeft;
    bit pausedDone;
    int expSeq [11] = '{0, 0, 0, 1, 2, 2, 3, 4, 4, 4, 4};

    RESET_N = 1'b0;
    START = 1'b0; ABORT = 1'b0; PAUSE = 1'b0; LOOP = 1'b0;
    CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
    modelReset();
    #12;
    $display("[TB] reset values");
    checkOutput();
    RESET_N = 1'b1;

    // Default entry 0 is long: phase 0 must still be active after 300 cycles
    $display("[TB] default table, partial run");
    startSeq();
    repeat (300) tick();
    checkValue("defPhase0Held", 32'(PHASE), 32'd0);
    abortSeq();

    // Shorten entries 0 and 4 so defaults 1..3 are exercised end to end
    $display("[TB] default middle entries");
    cfgWrite(0, 5);
    cfgWrite(4, 1);
    startSeq();
    runUntilIdle(10000, n);
    checkValue("defBusyLen", 32'(n), 32'd5656);
    checkValue("defDone", 32'(DONE), 32'd1);

    $display("[TB] table 3,1,2,0,4");
    cfgWrite(0, 3); cfgWrite(1, 1); cfgWrite(2, 2); cfgWrite(3, 0); cfgWrite(4, 4);
    startSeq();
    runUntilIdle(100, n);
    checkValue("seqBusyLen", 32'(n), 32'd11);
    for (int i = 0; i < 11 && i < phaseLog.size(); i++) begin
      checkValue("seqPhase", 32'(phaseLog[i]), 32'(expSeq[i]));
    end
    checkValue("seqDone", 32'(DONE), 32'd1);
    checkValue("seqReady", 32'(READY), 32'd1);

    $display("[TB] pause in phase 2");
    startSeq();
    n = 0;
    pauseLeft = 0;
    pausedDone = 1'b0;
    while (BUSY === 1'b1 && n < 100) begin
      n++;
      if (!pausedDone && PHASE == 3'd2) begin
        PAUSE = 1'b1;
        pauseLeft = 5;
        pausedDone = 1'b1;
      end
      tick();
      if (pauseLeft > 0) begin
        checkValue("pausePhase", 32'(PHASE), 32'd2);
        pauseLeft--;
        if (pauseLeft == 0) PAUSE = 1'b0;
      end
    end
    checkValue("pauseBusyLen", 32'(n), 32'd16);

    $display("[TB] abort in phase 1");
    cfgWrite(1, 3);
    startSeq();
    waitCnt = 0;
    while (PHASE != 3'd1 && waitCnt < 50) begin
      waitCnt++;
      tick();
    end
    checkValue("abortReachPhase1", 32'(PHASE), 32'd1);
    tick();
    abortSeq();
    checkValue("abortBusy", 32'(BUSY), 32'd0);
    checkValue("abortReady", 32'(READY), 32'd1);
    checkValue("abortPhase", 32'(PHASE), 32'd0);
    checkValue("abortDone", 32'(DONE), 32'd0);
    checkValue("abortStb", 32'(PHASE_STB), 32'd0);
    START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    checkValue("startAbortIdle", 32'(BUSY), 32'd0);
    tick();
    checkValue("startAbortStillIdle", 32'(READY), 32'd1);

    $display("[TB] loop mode");
    for (int i = 0; i < NUM_PHASES; i++) cfgWrite(i, 1);
    LOOP = 1'b1;
    startSeq();
    for (int i = 0; i < 12; i++) begin
      checkValue("loopPhase", 32'(PHASE), 32'(i % NUM_PHASES));
      if (i > 0) checkValue("loopStb", 32'(PHASE_STB), 32'd1);
      checkValue("loopNoDone", 32'(DONE), 32'd0);
      tick();
    end
    LOOP = 1'b0;
    runUntilIdle(50, n);
    checkValue("loopExitLen", 32'(n), 32'd3);
    checkValue("loopExitDone", 32'(DONE), 32'd1);

    $display("[TB] mid-run table writes");
    cfgWrite(0, 3); cfgWrite(1, 1); cfgWrite(2, 4); cfgWrite(3, 2); cfgWrite(4, 1);
    startSeq();
    for (int k = 0; k < NUM_PHASES; k++) phaseCount[k] = 0;
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      if (int'(PHASE) < NUM_PHASES) phaseCount[PHASE]++;
      CFG_WE = (n >= 4 && n <= 6);
      CFG_ADDR = (n == 4) ? 3'd2 : (n == 5) ? 3'd3 : 3'd7;
      CFG_DATA = (n == 6) ? CNT_W'(0) : CNT_W'(10);
      n++;
      tick();
    end
    CFG_WE = 1'b0;
    checkValue("midPhase2Kept", 32'(phaseCount[2]), 32'd4);
    checkValue("midPhase3Long", 32'(phaseCount[3]), 32'd10);
    checkValue("midBusyLen", 32'(n), 32'd19);
    startSeq();
    runUntilIdle(100, n);
    checkValue("midPhase2Next", 32'(phaseCount[2]), 32'd10);

    $display("[TB] reset mid-run");
    startSeq();
    repeat (3) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    modelReset();
    checkOutput();
    tick();
    #2;
    RESET_N = 1'b1;
    startSeq();
    repeat (100) tick();
    checkValue("resetDefaultsBack", 32'(PHASE), 32'd0);
    abortSeq();

    $display("[TB] randomized traffic");
    for (int i = 0; i < NUM_PHASES; i++) cfgWrite(i, int'($urandom_range(0, 3)));
    for (int i = 0; i < 1500; i++) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Programmable phase scheduler that steps a shared interval timer through a table of NUM_PHASES cycle-count durations and reports the active phase to downstream logic. It replaces hard-coded per-state count constants with a run-time writable duration table, a start/done handshake, pause, abort and loop modes. It sits between the system control logic, which issues START and CFG writes, and the power-up/refresh timing consumers, which observe PHASE, PHASE_STB and DONE.

## Interface
- NUM_PHASES, 5, number of table entries/phases (≥2)
- CNT_W, 22, duration and timer width in bits
- ADDR_W, derived localparam max(1, $clog2(NUM_PHASES)), not overridable
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  begin sequence; sampled only in IDLE
- ABORT  in  1  terminate sequence; highest priority
- PAUSE  in  1  freeze the timer while high (RUN only)
- LOOP  in  1  restart at phase 0 after the last phase instead of finishing
- CFG_WE  in  1  duration table write strobe
- CFG_ADDR  in  ADDR_W  table index
- CFG_DATA  in  CNT_W  duration in cycles
- READY  out  1  high in IDLE
- BUSY  out  1  high in RUN
- PHASE  out  ADDR_W  current phase index
- PHASE_STB  out  1  one-cycle pulse on every phase completion
- DONE  out  1  one-cycle pulse on normal sequence completion

## Operation
- FSM with states IDLE and RUN. All outputs are registered.
- Reset values: READY=1, BUSY=0, PHASE=0, PHASE_STB=0, DONE=0, timer=0, state=IDLE. The table reloads its defaults: 2000000, 1950, 1850, 1850, 76500 for entries 0–4. Entries at index ≥5 reset to 1.
- Table semantics:
  - An effective duration of 0 is treated as 1.
  - A write with CFG_ADDR ≥ NUM_PHASES is ignored.
  - Writes are accepted in any state.
  - A write to the entry currently counting does not alter the current countdown. It takes effect at that entry's next load.
- IDLE → RUN when START=1 and ABORT=0. Timer loads D[0]−1, PHASE=0.
- RUN, per cycle:
  - When PAUSE=0, the timer decrements.
  - When the timer is 0 and PAUSE=0, the phase ends.
- Phase end for PHASE<NUM_PHASES−1: PHASE increments, the timer loads D[PHASE+1]−1, PHASE_STB=1.
- Phase end for the last phase:
  - With LOOP=1 (sampled that cycle): PHASE=0, the timer reloads D[0]−1, PHASE_STB=1.
  - With LOOP=0: go to IDLE. PHASE=0, PHASE_STB=1, DONE=1.
- ABORT=1 in RUN: next cycle IDLE, PHASE=0. No PHASE_STB and no DONE. This holds regardless of PAUSE, START or a phase end on the same cycle.
- START in RUN is ignored. ABORT in IDLE is a no-op.
- Arithmetic: the unsigned timer decrement never underflows, because it is guarded by the zero check.

## Timing
- START sampled at edge e. BUSY=1 and PHASE=0 from cycle e+1.
- Phase k holds PHASE=k for exactly max(D[k],1) + (paused cycles within it) cycles.
- Without pause, BUSY stays high for Σ max(D[k],1) cycles.
- PHASE_STB and DONE are asserted in the first cycle of the new phase, or the first IDLE cycle.
- DONE, READY rising and BUSY falling all occur in the same cycle. START is accepted in that cycle.
- ABORT sampled at edge e gives BUSY=0 and READY=1 from cycle e+1.
- RESET_N low forces all reset values immediately, regardless of CLK, including mid-sequence.

## Structure
- phase_seq_pkg holds:
  - the state enum, seq_state_t {IDLE, RUN}
  - the default duration constants, DEF_DUR_0..DEF_DUR_4
  - the default CNT_W
- Sub-module interval_timer (CNT_W):
  - inputs CLK, RESET_N, LOAD, LOAD_VAL, EN
  - outputs COUNT and EXPIRE, where EXPIRE = (COUNT==0) & EN
  - LOAD overrides EN
- The table is a register array inside phase_sequencer, not RAM.

## Test plan
- Defaults after reset, then START pulse:
  - BUSY high for 2082150 cycles.
  - 5 PHASE_STB pulses at offsets 2000000, 2001950, 2003800, 2005650, 2082150 from BUSY rise.
  - DONE once with the last pulse.
- Program D=3,1,2,0,4, then START:
  - PHASE per cycle 0,0,0,1,2,2,3,4,4,4,4 (BUSY 11 cycles).
  - DONE and READY in cycle 12.
- Same table with PAUSE high for 5 cycles during phase 2:
  - BUSY 16 cycles, PHASE held at 2 throughout.
  - No PHASE_STB while paused.
- ABORT in second cycle of phase 1:
  - BUSY=0, PHASE=0 next cycle, no DONE, no PHASE_STB.
  - START+ABORT together in IDLE → stays IDLE.
- LOOP=1, D all 1:
  - PHASE 0,1,2,3,4,0,… with PHASE_STB every cycle, DONE never.
  - Drop LOOP during phase 2 → DONE after phase 4.
- Mid-run writes and reset:
  - CFG write of 10 to the current phase 2 keeps the old count; a write of 10 to phase 3 lengthens phase 3 to 10 cycles.
  - CFG_ADDR=7 write is ignored.
  - RESET_N low mid-run → immediate reset values and defaults restored.
